// File: rtl/dm_pkg.sv
// Shared definitions for the multi-cycle data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 10;
    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0000;

endpackage

// File: rtl/dm_array.sv
// Word array with synchronous active-low clear, per-byte write enables
// and a combinational read port.
module dm_array
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i[DEPTH_LOG2-1:0]] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b[1:0]]) begin
                    mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU load/store port: one request at a time, WAIT_CYCLES
// wait states, then a single-cycle ready response with read data or error.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned CW         = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [32:0] ADDR_LIMIT = 33'd4 << DEPTH_LOG2;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  enter_resp;
    logic                  lat_we;
    logic [31:0]           lat_addr, lat_wdata;
    logic [3:0]            lat_be;
    logic                  cur_we;
    logic [31:0]           cur_addr, cur_wdata;
    logic [3:0]            cur_be;
    logic [31:0]           offset;
    logic                  acc_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            mem_we;
    logic [31:0]           mem_rdata;
    logic [31:0]           rdata_q;
    logic                  err_q;

    // With zero wait states RESP is entered on the accepting edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        cur_we    = (state == S_IDLE) ? we    : lat_we;
        cur_addr  = (state == S_IDLE) ? addr  : lat_addr;
        cur_wdata = (state == S_IDLE) ? wdata : lat_wdata;
        cur_be    = (state == S_IDLE) ? be    : lat_be;
    end

    always_comb begin
        offset   = cur_addr - BASE_ADDR;
        acc_err  = (cur_addr[1:0] != 2'b00) || ({1'b0, offset} >= ADDR_LIMIT);
        word_idx = offset[DEPTH_LOG2+1:2];
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nx = CW'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nx   = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem_we = (enter_resp && cur_we && !acc_err) ? cur_be : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && req) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_be    <= be;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (cur_we || acc_err) ? '0 : mem_rdata;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    assign ready = (state == S_RESP);
    assign busy  = (state != S_IDLE);
    assign rdata = rdata_q;
    assign err   = err_q;

    dm_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .clr_n(rst),
        .we   (mem_we),
        .waddr(word_idx),
        .wdata(cur_wdata),
        .raddr(word_idx),
        .rdata(mem_rdata)
    );

endmodule
